// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder/subtractor, one bit per clock, LSB first.
// Subtraction is a + ~b + 1, with the +1 injected through the initial carry.
module serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               c_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;

    logic [WIDTH-1:0]   a_sr_q;
    logic [WIDTH-1:0]   b_sr_q;
    logic [WIDTH-2:0]   res_q;

    logic               s_d;
    logic               c_d;
    logic [WIDTH-1:0]   res_d;
    logic               last_bit;

    always_comb begin
        s_d      = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
        c_d      = (a_sr_q[0] & b_sr_q[0]) | (c_q & (a_sr_q[0] ^ b_sr_q[0]));
        res_d    = {s_d, res_q};
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        c_q     <= sub;
                    end
                end
                RUN: begin
                    c_q   <= c_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_bit) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= res_d;
                        cout_q  <= c_d;
                        // Carry into the MSB is c_q at this edge; carry out is c_d.
                        ovf_q   <= c_q ^ c_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // NOTE: the shift registers carry no reset; they are always reloaded on
    // start before being read, so a reset would only add fan-out on rst_n.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            a_sr_q <= a;
            b_sr_q <= sub ? ~b : b;
        end else if (state_q == RUN) begin
            a_sr_q <= a_sr_q >> 1;
            b_sr_q <= b_sr_q >> 1;
            res_q  <= res_d[WIDTH-1:1];
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=16: arithmetic corners,
// ignored start, asynchronous reset mid-operation and back-to-back throughput.
module tb_serial_adder;

    localparam int WIDTH = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              sub;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  sum;
    logic              carry_out;
    logic              overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operation from an IDLE start; inj>0 pulses a stray start before RUN edge inj.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic sv, input logic [15:0] es, input logic eco,
                          input logic eov, input int inj);
        int n;
        logic [15:0] s0;
        logic c0;
        logic v0;
        logic stable;
        @(negedge clk);
        a = av; b = bv; sub = sv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
        s0 = sum; c0 = carry_out; v0 = overflow; stable = 1'b1; n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (n + 1 == inj) begin
                start = 1'b1; a = 16'd1; b = 16'd1; sub = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (busy === 1'b1 && (sum !== s0 || carry_out !== c0 || overflow !== v0 || done !== 1'b0))
                stable = 1'b0;
        end
        start = 1'b0;
        check({tag, ".busy_cycles"}, n, WIDTH);
        check({tag, ".stable_run"}, stable, 1'b1);
        check({tag, ".done"}, done, 1'b1);
        check({tag, ".sum"}, sum, es);
        check({tag, ".carry_out"}, carry_out, eco);
        check({tag, ".overflow"}, overflow, eov);
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, done, 1'b0);
        check({tag, ".idle_after"}, busy, 1'b0);
    endtask

    initial begin
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic        vs [3];
        logic [15:0] ves [3];
        logic        veco [3];
        logic        veov [3];
        int          pulses;
        int          last_done;
        logic        stable;
        logic [15:0] s_prev;
        logic        c_prev;
        logic        v_prev;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        #12;
        check("reset.busy", busy, 1'b0);
        check("reset.done", done, 1'b0);
        check("reset.sum", sum, 16'h0000);
        check("reset.carry_out", carry_out, 1'b0);
        check("reset.overflow", overflow, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op("add_5_3",      16'd5,     16'd3,     1'b0, 16'h0008, 1'b0, 1'b0, 0);
        run_op("add_ffff_1",   16'hFFFF,  16'h0001,  1'b0, 16'h0000, 1'b1, 1'b0, 0);
        run_op("add_7fff_1",   16'h7FFF,  16'h0001,  1'b0, 16'h8000, 1'b0, 1'b1, 0);
        run_op("sub_3_5",      16'd3,     16'd5,     1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
        run_op("ignored_start",16'd5,     16'd3,     1'b0, 16'h0008, 1'b0, 1'b0, 5);
        run_op("sub_8000_1",   16'h8000,  16'h0001,  1'b1, 16'h7FFF, 1'b1, 1'b1, 0);

        // Abort an add between E7 and E8; outputs must clear without a clock edge.
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("abort.busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort.busy", busy, 1'b0);
        check("abort.done", done, 1'b0);
        check("abort.sum", sum, 16'h0000);
        check("abort.carry_out", carry_out, 1'b0);
        check("abort.overflow", overflow, 1'b0);
        @(posedge clk); #1;
        check("abort.no_done", done, 1'b0);
        rst_n = 1'b1;
        run_op("after_reset", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 0);

        // start held high; only the operands present at each accepting edge matter.
        va[0] = 16'h0F0F; vb[0] = 16'h1010; vs[0] = 1'b0; ves[0] = 16'h1F1F; veco[0] = 1'b0; veov[0] = 1'b0;
        va[1] = 16'h8000; vb[1] = 16'h8000; vs[1] = 1'b1; ves[1] = 16'h0000; veco[1] = 1'b1; veov[1] = 1'b0;
        va[2] = 16'hC000; vb[2] = 16'hC000; vs[2] = 1'b0; ves[2] = 16'h8000; veco[2] = 1'b1; veov[2] = 1'b0;
        pulses = 0; last_done = -1; stable = 1'b1;
        s_prev = sum; c_prev = carry_out; v_prev = overflow;
        for (int t = 0; t <= 53; t++) begin
            start = 1'b1;
            if (t % 18 == 0 && t / 18 < 3) begin
                a = va[t / 18]; b = vb[t / 18]; sub = vs[t / 18];
            end else begin
                a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
            end
            @(posedge clk); #1;
            if (done === 1'b1) begin
                if (last_done < 0) check("b2b.first_done_edge", t, 16);
                else check("b2b.done_spacing", t - last_done, WIDTH + 2);
                if (pulses < 3) begin
                    check("b2b.sum", sum, ves[pulses]);
                    check("b2b.carry_out", carry_out, veco[pulses]);
                    check("b2b.overflow", overflow, veov[pulses]);
                end
                last_done = t;
                pulses++;
            end else if (sum !== s_prev || carry_out !== c_prev || overflow !== v_prev) begin
                stable = 1'b0;
            end
            s_prev = sum; c_prev = carry_out; v_prev = overflow;
        end
        start = 1'b0;
        check("b2b.pulses", pulses, 3);
        check("b2b.stable", stable, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
